// File: rtl/hbmc_dru_gen_if.sv
// Oversampled HyperBus read-path bus: sample inputs from the ISERDES packer
// and the recovered word/error outputs toward the read FIFO.
interface hbmc_dru_gen_if #(
  parameter int DQ_WIDTH = 8,
  parameter int NSAMP    = 6
);
  logic [NSAMP-1:0]          rwds_oversampled;
  logic [DQ_WIDTH*NSAMP-1:0] data_oversampled;
  logic                      recov_valid;
  logic [2*DQ_WIDTH-1:0]     recov_data;
  logic                      err_glitch;
  logic                      err_align;

  modport master (
    output rwds_oversampled, data_oversampled,
    input  recov_valid, recov_data, err_glitch, err_align
  );

  modport slave (
    input  rwds_oversampled, data_oversampled,
    output recov_valid, recov_data, err_glitch, err_align
  );
endinterface

// File: rtl/hbmc_dru_gen.sv
// HyperBus data recovery unit: finds RWDS edges in the oversampled stream,
// captures one DQ byte per edge and pairs rising/falling bytes into words.
module hbmc_dru_gen #(
  parameter int DQ_WIDTH   = 8,
  parameter int NSAMP      = 6,
  parameter int SAMPLE_OFS = 1,
  parameter int MIN_GAP    = 2,
  parameter int STALL_CYC  = 4
) (
  input  logic           i_clk,
  input  logic           i_arstn,
  input  logic           i_clear,
  hbmc_dru_gen_if.slave  s_bus
);

  localparam int POS_W   = $clog2(NSAMP);
  localparam int LANE_IW = $clog2(2*NSAMP);
  localparam int STALL_W = $clog2(STALL_CYC+1);

  typedef enum logic {IDLE, HAVE_FIRST} state_t;

  logic                      r_lastSample;
  logic [NSAMP-1:0]          r_aEdge, r_aRise, r_bEdge, r_bRise;
  logic [DQ_WIDTH*NSAMP-1:0] r_aData, r_bData;
  logic [NSAMP-1:0]          w_prevVec;

  state_t                    r_state;
  logic [DQ_WIDTH-1:0]       r_temp;
  logic [STALL_W-1:0]        r_stall;
  logic                      r_valid;
  logic [2*DQ_WIDTH-1:0]     r_data;
  logic                      r_errGlitch, r_errAlign;
  logic                      r_prevValid;
  logic [POS_W-1:0]          r_prevPos;

  logic [2*NSAMP-1:0]        w_lane [DQ_WIDTH];
  logic [1:0]                w_byteCnt;
  logic                      w_b0Rise;
  logic [DQ_WIDTH-1:0]       w_b0, w_b1;
  logic                      w_glitch;
  logic [POS_W-1:0]          w_lastPos;

  assign w_prevVec = {s_bus.rwds_oversampled[NSAMP-2:0], r_lastSample};

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_lastSample <= 1'b0;
      r_aEdge      <= '0;
      r_aRise      <= '0;
      r_aData      <= '0;
      r_bEdge      <= '0;
      r_bRise      <= '0;
      r_bData      <= '0;
    end else begin
      r_lastSample <= s_bus.rwds_oversampled[NSAMP-1];
      r_aEdge      <= s_bus.rwds_oversampled ^ w_prevVec;
      r_aRise      <= s_bus.rwds_oversampled & ~w_prevVec;
      r_aData      <= s_bus.data_oversampled;
      r_bEdge      <= r_aEdge;
      r_bRise      <= r_aRise;
      r_bData      <= r_aData;
    end
  end

  // Each DQ lane viewed as Stage B samples followed by Stage A samples, so a
  // capture point past the end of the B cycle lands in the next cycle's data.
  for (genvar g = 0; g < DQ_WIDTH; g++) begin : g_lane
    assign w_lane[g] = {r_aData[NSAMP*g +: NSAMP], r_bData[NSAMP*g +: NSAMP]};
  end

  always_comb begin
    int                  lastPos;
    int                  cnt;
    logic                haveLast;
    logic [LANE_IW-1:0]  pIdx;
    logic [DQ_WIDTH-1:0] byteVal;
    lastPos   = int'(r_prevPos) - NSAMP;
    cnt       = 0;
    haveLast  = r_prevValid;
    pIdx      = '0;
    byteVal   = '0;
    w_b0      = '0;
    w_b1      = '0;
    w_b0Rise  = 1'b0;
    w_glitch  = 1'b0;
    w_byteCnt = '0;
    w_lastPos = '0;
    for (int j = 0; j < NSAMP; j++) begin
      if (r_bEdge[j]) begin
        if (haveLast && ((j - lastPos) < MIN_GAP)) w_glitch = 1'b1;
        pIdx = LANE_IW'(j + SAMPLE_OFS);
        for (int i = 0; i < DQ_WIDTH; i++) byteVal[i] = w_lane[i][pIdx];
        if (cnt == 0) begin
          w_b0     = byteVal;
          w_b0Rise = r_bRise[j];
        end else if (cnt == 1) begin
          w_b1 = byteVal;
        end
        cnt       = cnt + 1;
        lastPos   = j;
        haveLast  = 1'b1;
        w_lastPos = POS_W'(j);
      end
    end
    if (cnt > 2) w_glitch = 1'b1;
    w_byteCnt = (cnt > 2) ? 2'd2 : 2'(cnt);
  end

  // Pairing FSM; two bytes in one cycle always alternate polarity when the
  // spacing check passes, so only the first byte's polarity is needed.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state     <= IDLE;
      r_temp      <= '0;
      r_stall     <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_errGlitch <= 1'b0;
      r_errAlign  <= 1'b0;
      r_prevValid <= 1'b0;
      r_prevPos   <= '0;
    end else begin
      r_valid     <= 1'b0;
      r_errGlitch <= 1'b0;
      r_errAlign  <= 1'b0;
      r_prevValid <= (w_byteCnt != 2'd0);
      if (w_byteCnt != 2'd0) r_prevPos <= w_lastPos;
      if (i_clear) begin
        r_state <= IDLE;
        r_temp  <= '0;
        r_stall <= '0;
      end else if (w_glitch) begin
        r_errGlitch <= 1'b1;
        r_state     <= IDLE;
        r_stall     <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_byteCnt == 2'd1) begin
              if (w_b0Rise) begin
                r_temp  <= w_b0;
                r_stall <= '0;
                r_state <= HAVE_FIRST;
              end else begin
                r_errAlign <= 1'b1;
              end
            end else if (w_byteCnt == 2'd2) begin
              if (w_b0Rise) begin
                r_data  <= {w_b0, w_b1};
                r_valid <= 1'b1;
              end else begin
                r_errAlign <= 1'b1;
                r_temp     <= w_b1;
                r_stall    <= '0;
                r_state    <= HAVE_FIRST;
              end
            end
          end
          HAVE_FIRST: begin
            if (w_byteCnt == 2'd0) begin
              if (r_stall == STALL_W'(STALL_CYC-1)) begin
                r_errAlign <= 1'b1;
                r_stall    <= '0;
                r_state    <= IDLE;
              end else begin
                r_stall <= r_stall + 1'b1;
              end
            end else if (w_byteCnt == 2'd1) begin
              if (w_b0Rise) begin
                r_temp  <= w_b0;
                r_stall <= '0;
              end else begin
                r_data  <= {r_temp, w_b0};
                r_valid <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              if (w_b0Rise) begin
                r_data  <= {w_b0, w_b1};
                r_valid <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_data  <= {r_temp, w_b0};
                r_valid <= 1'b1;
                r_temp  <= w_b1;
                r_stall <= '0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign s_bus.recov_valid = r_valid;
  assign s_bus.recov_data  = r_data;
  assign s_bus.err_glitch  = r_errGlitch;
  assign s_bus.err_align   = r_errAlign;

endmodule
